// File: rtl/reg_mask_encoder.sv
// reg_mask_encoder
//   Sequential 32-to-5 encoder. It accepts a register mask and emits the
//   5-bit index of each set bit, one index per idx handshake. It turns a
//   one-hot or multi-hot register vector back into register-file addresses,
//   for uses such as dirty-register flush and multi-register save/restore.
//
// Parameters
//   SKIP_X0    1: bit 0 of the captured mask is cleared, so x0 is never emitted
//   ASCENDING  1: lowest set index first; 0: highest set index first
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   mask_in     register mask to encode
//   mask_valid  mask_in is valid
//   mask_ready  a mask can be accepted (high only in IDLE)
//   flush       synchronous abort of the current mask
//   idx_out     current register index (0 when idx_valid is low)
//   idx_valid   idx_out is valid
//   idx_ready   consumer accepts idx_out
//   idx_last    idx_out is the final index of the current mask
//   done        one-cycle pulse when a mask has been fully emitted
//   count       indices accepted for the current or most recent mask
module reg_mask_encoder #(
    parameter bit SKIP_X0   = 1'b1,
    parameter bit ASCENDING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mask_in,
    input  logic        mask_valid,
    output logic        mask_ready,
    input  logic        flush,
    output logic [4:0]  idx_out,
    output logic        idx_valid,
    input  logic        idx_ready,
    output logic        idx_last,
    output logic        done,
    output logic [5:0]  count
);

    localparam int unsigned MASK_W = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e              state_q;
    logic [MASK_W-1:0]   pending_q;
    logic [CNT_W-1:0]    count_q;
    logic                done_q;

    logic [IDX_W-1:0]    enc_idx;
    logic [MASK_W-1:0]   pending_clr;
    logic [MASK_W-1:0]   capture;
    logic                scan_active;
    logic                single_bit;

    // Priority encoder over pending; the last match in loop order wins.
    always_comb begin
        enc_idx = '0;
        if (ASCENDING) begin
            for (int i = int'(MASK_W) - 1; i >= 0; i--) begin
                if (pending_q[i]) begin
                    enc_idx = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < int'(MASK_W); i++) begin
                if (pending_q[i]) begin
                    enc_idx = IDX_W'(i);
                end
            end
        end
    end

    // Mask as stored at capture, with x0 optionally removed.
    assign capture = SKIP_X0 ? {mask_in[MASK_W-1:1], 1'b0} : mask_in;

    // Pending set after the current index is handed off.
    assign pending_clr = pending_q & ~(MASK_W'(1) << enc_idx);

    // A power of two (or zero) has no bits left after clearing its lowest set bit.
    assign single_bit  = ((pending_q & (pending_q - MASK_W'(1))) == '0);

    assign scan_active = (state_q == SCAN) && (pending_q != '0);

    // Index outputs decode registered state only, so they are valid on SCAN entry.
    assign mask_ready = (state_q == IDLE);
    assign idx_valid  = scan_active;
    assign idx_out    = scan_active ? enc_idx : '0;
    assign idx_last   = scan_active && single_bit;
    assign done       = done_q;
    assign count      = count_q;

    // Control FSM: capture in IDLE, drain pending in SCAN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // flush wins over a coincident capture
                    if (mask_valid && !flush) begin
                        pending_q <= capture;
                        count_q   <= '0;
                        state_q   <= SCAN;
                    end
                end
                SCAN: begin
                    if (flush) begin
                        // abort: drop remaining indices, count keeps its value
                        pending_q <= '0;
                        state_q   <= IDLE;
                    end else if (!scan_active) begin
                        // empty mask spends one SCAN cycle, then finishes
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (idx_ready) begin
                        pending_q <= pending_clr;
                        count_q   <= count_q + CNT_W'(1);
                        if (pending_clr == '0) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_mask_encoder.md
Name: reg_mask_encoder

Overview:
- Sequential 32-to-5 encoder: accepts a 32-bit register mask and emits the 5-bit index of each set bit, one per handshake.
- Inverse of the register-file write-select decoder: it turns a one-hot or multi-hot register vector back into register addresses.
- Sits in Stage2 beside the RegisterFile and feeds index streams (dirty-register flush, multi-register save/restore) to the register-file address port.

Parameters:
- SKIP_X0, 1, when 1, bit 0 of the accepted mask is cleared at capture (x0 is never emitted).
- ASCENDING, 1, when 1, emit the lowest set index first; when 0, emit the highest set index first.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- mask_in  in  32  register mask to encode.
- mask_valid  in  1  mask_in is valid.
- mask_ready  out  1  block can accept a mask (high only in IDLE).
- flush  in  1  synchronous abort of the current mask.
- idx_out  out  5  current encoded register index.
- idx_valid  out  1  idx_out is valid.
- idx_ready  in  1  consumer accepts idx_out.
- idx_last  out  1  idx_out is the final index of the current mask.
- done  out  1  one-cycle pulse when a mask has been fully emitted.
- count  out  6  number of indices accepted for the current or most recent mask.

Behaviour:
- Reset (asynchronous, on rst high):
  - state=IDLE, pending=0, count=0, done=0.
  - Outputs during and after reset: mask_ready=1, idx_valid=0, idx_out=0, idx_last=0.
- State machine has two states, IDLE and SCAN. pending[31:0] is a register.
- IDLE:
  - mask_ready=1 and idx_valid=0.
  - On mask_valid & mask_ready: pending <= mask_in with bit 0 cleared if SKIP_X0; count <= 0.
  - The next state is SCAN in all cases, even if the captured mask is zero.
- SCAN:
  - mask_ready=0.
  - idx_valid = (pending != 0).
  - idx_out = priority encode of pending: lowest set bit if ASCENDING, highest set bit otherwise. This is a combinational function of registered pending, so there is zero latency from entering SCAN.
  - idx_last = idx_valid & (pending has exactly one bit set), i.e. (pending & (pending-1)) == 0.
  - On idx_valid & idx_ready: clear bit idx_out in pending; count <= count+1.
  - When pending==0, or is cleared to 0 by the final transfer: the next state is IDLE and done=1 for exactly one cycle. That cycle is the cycle in which state returns to IDLE.
- Empty mask (captured value 0, or only bit 0 with SKIP_X0=1):
  - One SCAN cycle with idx_valid=0.
  - Then IDLE with a done pulse; count=0.
- Latency:
  - Mask accept at edge N gives the first idx_valid in cycle N+1.
  - Each subsequent index becomes valid the cycle after the previous one is accepted.
  - Full throughput is one index per cycle with idx_ready held high.
- Backpressure:
  - While idx_valid & !idx_ready, idx_out, idx_last and pending hold stable.
  - idx_valid never drops without a transfer, except on flush or rst.
- Flush:
  - flush=1 in SCAN: pending <= 0, next state IDLE, no done pulse, count holds.
  - If flush coincides with a transfer, the transfer does not count: count is not incremented.
  - flush in IDLE has priority over capture: the mask is not accepted and mask_ready stays 1 (combinational), but the handshake is ignored that cycle.
- idx_out is forced to 0 whenever idx_valid=0.
- count saturates naturally at 32: at most 32 indices, 6 bits.
- rst mid-SCAN: immediate return to the reset values above; the remaining indices are discarded.

Test Plan:
- Reset, then mask_in=0x0000_0001, SKIP_X0=1, idx_ready=1 -> no idx_valid; done pulses 2 cycles after accept; count=0.
- mask_in=0x8000_0014, ASCENDING=1, idx_ready=1 -> idx_out 2, 4, 31 on consecutive cycles; idx_last only with 31; done next cycle; count=3.
- Same mask, ASCENDING=0 -> idx_out 31, 4, 2; idx_last with 2.
- mask_in=0xFFFF_FFFF, SKIP_X0=0, idx_ready toggling 1/0 -> indices 0..31 in order; each held stable while idx_ready=0; count=32; exactly one done pulse.
- mask_in=0x0000_0F00, flush asserted after index 9 is accepted -> indices 8, 9 only; no done pulse; mask_ready=1 next cycle; count=2.
- Assert rst asynchronously mid-SCAN with mask 0x00F0_0000 -> idx_valid=0 and mask_ready=1 immediately; a new mask 0x0000_0002 then yields idx_out=1 with idx_last=1.
